// File: rtl/iir_mc_pkg.sv
// Shared definitions for the multi-channel biquad: tap indices, FSM states,
// accumulator sizing and the saturation range check.
package iir_mc_pkg;

  localparam int unsigned NUM_TAPS = 5;

  localparam logic [2:0] IDX_B0 = 3'd0;
  localparam logic [2:0] IDX_B1 = 3'd1;
  localparam logic [2:0] IDX_B2 = 3'd2;
  localparam logic [2:0] IDX_A1 = 3'd3;
  localparam logic [2:0] IDX_A2 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_OUT
  } state_e;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_e;

  // Three guard bits cover the sum of five full-scale products.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 3;
  endfunction

  function automatic sat_e sat_check(input logic signed [127:0] v, input int dw);
    logic signed [127:0] hi;
    logic signed [127:0] lo;
    hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
    lo = -(128'sd1 <<< (dw - 1));
    if (v > hi) return SAT_POS;
    if (v < lo) return SAT_NEG;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Shared signed multiply-accumulate with a registered accumulator; the
// output is the accumulator scaled down by FRAC and clamped to DATA_W.
module iir_mac_sat
  import iir_mc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     sub_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic signed [DATA_W-1:0] opnd_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam int ACC_W = acc_width(DATA_W, COEF_W);
  localparam int PRD_W = DATA_W + COEF_W;

  logic signed [PRD_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] shifted;
  logic signed [127:0]     shifted_ext;

  assign prod     = PRD_W'(coef_i) * PRD_W'(opnd_i);
  assign prod_ext = {{(ACC_W - PRD_W){prod[PRD_W-1]}}, prod};

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sub_i ? (acc_q - prod_ext) : (acc_q + prod_ext);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          acc_q <= '0;
    else if (clk_enable) acc_q <= acc_d;
  end

  // Arithmetic shift truncates toward -inf before the clamp.
  assign shifted     = acc_q >>> FRAC;
  assign shifted_ext = {{(128 - ACC_W){shifted[ACC_W-1]}}, shifted};

  always_comb begin
    case (sat_check(shifted_ext, DATA_W))
      SAT_POS: y_o = {1'b0, {(DATA_W-1){1'b1}}};
      SAT_NEG: y_o = {1'b1, {(DATA_W-1){1'b0}}};
      default: y_o = shifted[DATA_W-1:0];
    endcase
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed direct-form-I biquad: one MAC serves NUM_CH channels,
// each with its own coefficients and x/y history.
module iir_biquad_mc
  import iir_mc_pkg::*;
#(
  parameter int  DATA_W = 32,
  parameter int  COEF_W = 16,
  parameter int  FRAC   = 14,
  parameter int  NUM_CH = 2,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_enable,
  input  logic                     start_coe,
  input  logic                     coe_we,
  input  logic [CH_W-1:0]          coe_ch,
  input  logic [2:0]               coe_idx,
  input  logic signed [COEF_W-1:0] coe_data,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic [CH_W-1:0]          in_ch,
  input  logic                     in_valid,
  input  logic                     hold,
  output logic                     start_togivedata,
  output logic signed [DATA_W-1:0] data_out,
  output logic [CH_W-1:0]          out_ch,
  output logic                     start_toread
);

  state_e                   state_q;
  logic [2:0]               tap_q;
  logic signed [DATA_W-1:0] x_q;
  logic [CH_W-1:0]          ch_q;
  logic                     chv_q;
  logic                     coe_run_q;
  logic signed [DATA_W-1:0] data_out_q;
  logic [CH_W-1:0]          out_ch_q;
  logic                     toread_q;

  logic signed [COEF_W-1:0] coef_q [NUM_CH][NUM_TAPS];
  logic signed [DATA_W-1:0] x1_q   [NUM_CH];
  logic signed [DATA_W-1:0] x2_q   [NUM_CH];
  logic signed [DATA_W-1:0] y1_q   [NUM_CH];
  logic signed [DATA_W-1:0] y2_q   [NUM_CH];

  logic                     idle;
  logic                     coe_rise;
  logic                     ready;
  logic                     accept;
  logic                     in_ch_ok;
  logic                     coe_wr;
  logic [CH_W-1:0]          hidx;
  logic signed [COEF_W-1:0] mac_coef;
  logic signed [DATA_W-1:0] mac_opnd;
  logic signed [DATA_W-1:0] y_sat;

  // start_coe is only tracked in IDLE so a rise during a computation is
  // seen (and clears histories) once the FSM is back in IDLE.
  assign idle     = (state_q == ST_IDLE);
  assign coe_rise = idle & start_coe & ~coe_run_q;
  assign ready    = idle & start_coe & ~hold & ~coe_rise;
  assign accept   = ready & in_valid;
  assign in_ch_ok = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
  assign coe_wr   = coe_we & (~start_coe | coe_rise) & (coe_idx <= IDX_A2)
                  & ({1'b0, coe_ch} < (CH_W+1)'(NUM_CH));

  assign hidx = chv_q ? ch_q : '0;

  always_comb begin
    mac_coef = coef_q[hidx][tap_q];
    case (tap_q)
      IDX_B0:  mac_opnd = x_q;
      IDX_B1:  mac_opnd = x1_q[hidx];
      IDX_B2:  mac_opnd = x2_q[hidx];
      IDX_A1:  mac_opnd = y1_q[hidx];
      IDX_A2:  mac_opnd = y2_q[hidx];
      default: mac_opnd = x_q;
    endcase
  end

  iir_mac_sat #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .FRAC  (FRAC)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clk_enable(clk_enable),
    .clr_i     (accept),
    .en_i      (state_q == ST_MAC),
    .sub_i     (tap_q >= IDX_A1),
    .coef_i    (mac_coef),
    .opnd_i    (mac_opnd),
    .y_o       (y_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tap_q      <= IDX_B0;
      x_q        <= '0;
      ch_q       <= '0;
      chv_q      <= 1'b0;
      coe_run_q  <= 1'b0;
      data_out_q <= '0;
      out_ch_q   <= '0;
      toread_q   <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        x1_q[c] <= '0;
        x2_q[c] <= '0;
        y1_q[c] <= '0;
        y2_q[c] <= '0;
        for (int k = 0; k < NUM_TAPS; k++) coef_q[c][k] <= '0;
      end
    end else if (clk_enable) begin
      toread_q <= 1'b0;
      if (idle) coe_run_q <= start_coe;
      if (coe_wr) coef_q[coe_ch][coe_idx] <= coe_data;
      if (coe_rise) begin
        for (int c = 0; c < NUM_CH; c++) begin
          x1_q[c] <= '0;
          x2_q[c] <= '0;
          y1_q[c] <= '0;
          y2_q[c] <= '0;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            x_q     <= data_in;
            ch_q    <= in_ch;
            chv_q   <= in_ch_ok;
            tap_q   <= IDX_B0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          // Samples tagged with a non-existent channel are dropped silently.
          if (tap_q == IDX_A2) state_q <= chv_q ? ST_OUT : ST_IDLE;
          else                 tap_q   <= tap_q + 3'd1;
        end
        ST_OUT: begin
          data_out_q <= y_sat;
          out_ch_q   <= ch_q;
          toread_q   <= 1'b1;
          x2_q[ch_q] <= x1_q[ch_q];
          x1_q[ch_q] <= x_q;
          y2_q[ch_q] <= y1_q[ch_q];
          y1_q[ch_q] <= y_sat;
          state_q    <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign start_togivedata = ready;
  assign data_out         = data_out_q;
  assign out_ch           = out_ch_q;
  assign start_toread     = toread_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// Directed bench for iir_biquad_mc: expected outputs are queued at accept
// time and matched against each start_toread pulse.
module tb_iir_biquad_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        start_coe;
  logic        coe_we;
  logic [0:0]  coe_ch;
  logic [2:0]  coe_idx;
  logic [15:0] coe_data;
  logic [31:0] data_in;
  logic [0:0]  in_ch;
  logic        in_valid;
  logic        hold;
  logic        start_togivedata;
  logic [31:0] data_out;
  logic [0:0]  out_ch;
  logic        start_toread;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;
  logic seen;

  typedef struct {
    logic [31:0] d;
    logic [0:0]  ch;
    int          t;
  } exp_t;

  exp_t sb[$];

  iir_biquad_mc #(
    .DATA_W(32),
    .COEF_W(16),
    .FRAC  (14),
    .NUM_CH(2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .start_coe       (start_coe),
    .coe_we          (coe_we),
    .coe_ch          (coe_ch),
    .coe_idx         (coe_idx),
    .coe_data        (coe_data),
    .data_in         (data_in),
    .in_ch           (in_ch),
    .in_valid        (in_valid),
    .hold            (hold),
    .start_togivedata(start_togivedata),
    .data_out        (data_out),
    .out_ch          (out_ch),
    .start_toread    (start_toread)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wcoef(input logic [0:0] ch, input logic [2:0] idx, input logic [15:0] val);
    coe_we = 1'b1; coe_ch = ch; coe_idx = idx; coe_data = val;
    @(negedge clk);
    coe_we = 1'b0;
  endtask

  task automatic send(input logic [0:0] ch, input logic [31:0] x, input logic [31:0] expv);
    int n = 0;
    while (start_togivedata !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", start_togivedata, 1);
    in_ch = ch; data_in = x; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back('{expv, ch, cyc});
  endtask

  task automatic collect(input string tag, input int lat);
    exp_t e;
    int n = 0;
    while (start_toread !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, start_toread, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_data"}, data_out, e.d);
      chk({tag, "_ch"}, out_ch, e.ch);
      chk({tag, "_lat"}, cyc - e.t, lat);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, start_toread, 0);
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1; start_coe = 1'b1; coe_we = 1'b0;
    coe_ch = '0; coe_idx = '0; coe_data = '0; data_in = '0; in_ch = '0;
    in_valid = 1'b0; hold = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_dout", data_out, 0);
    chk("rst_och", out_ch, 0);
    chk("rst_rd", start_toread, 0);
    chk("rst_rdy", start_togivedata, 0);

    reset = 1'b1; start_coe = 1'b0;
    @(negedge clk);
    wcoef(0, 3'd0, 16'd16384);
    wcoef(1, 3'd0, 16'd16384);
    wcoef(1, 3'd3, 16'hE000);
    wcoef(0, 3'd5, 16'h1234);
    start_coe = 1'b1;
    #1 chk("rise_blk", start_togivedata, 0);
    @(negedge clk);
    chk("rise_rdy", start_togivedata, 1);

    send(0, 32'd1000, 32'd1000);             collect("pt0", 6);
    send(0, 32'hFFFF_FFF9, 32'hFFFF_FFF9);   collect("pt1", 6);
    send(0, 32'h1234_5678, 32'h1234_5678);   collect("pt2", 6);

    send(1, 32'd1000, 32'd1000);             collect("dk0", 6);
    send(0, 32'd55, 32'd55);                 collect("il0", 6);
    send(1, 32'd0, 32'd500);                 collect("dk1", 6);
    send(1, 32'd0, 32'd250);                 collect("dk2", 6);
    send(0, 32'hFFFF_FFFD, 32'hFFFF_FFFD);   collect("il1", 6);
    send(1, 32'd0, 32'd125);                 collect("dk3", 6);
    send(1, 32'd0, 32'd62);                  collect("dk4", 6);
    send(1, 32'd0, 32'd31);                  collect("dk5", 6);

    wcoef(0, 3'd0, 16'd0);
    send(0, 32'd77, 32'd77);                 collect("weign", 6);

    start_coe = 1'b0; @(negedge clk);
    start_coe = 1'b1; @(negedge clk);
    send(1, 32'd1000, 32'd1000);             collect("tog", 6);

    start_coe = 1'b0; @(negedge clk);
    start_coe = 1'b1;
    wcoef(1, 3'd0, 16'd8192);
    send(1, 32'd1000, 32'd500);              collect("risewr", 6);

    hold = 1'b1; in_ch = 0; data_in = 32'h0000_DEAD; in_valid = 1'b1; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hold_rdy", start_togivedata, 0);
      seen = seen | start_toread;
    end
    in_valid = 1'b0; hold = 1'b0;
    chk("hold_nord", seen, 0);

    send(0, 32'd123, 32'd123);
    @(negedge clk);
    hold = 1'b1;
    collect("hmac", 6);
    chk("hmac_rdy", start_togivedata, 0);
    hold = 1'b0;

    send(0, 32'd321, 32'd321);
    repeat (2) @(negedge clk);
    clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    clk_enable = 1'b1;
    collect("cen", 9);

    start_coe = 1'b0; @(negedge clk);
    wcoef(0, 3'd0, 16'd32767);
    start_coe = 1'b1; @(negedge clk);
    send(0, 32'h7FFF_FFFF, 32'h7FFF_FFFF);   collect("satp", 6);
    send(0, 32'h8000_0000, 32'h8000_0000);   collect("satn", 6);

    send(0, 32'd500, 32'd500);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mrst_dout", data_out, 0);
    chk("mrst_och", out_ch, 0);
    chk("mrst_rd", start_toread, 0);
    chk("mrst_rdy", start_togivedata, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | start_toread;
    end
    chk("mrst_nord", seen, 0);
    send(0, 32'd1000, 32'd0);                collect("mrst_zero", 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
